// File: rtl/i2c_slave_pkg.sv
// ============================================================================
// Module      : i2c_slave_pkg
// Description : Shared state encoding and bus-level constants for the I2C
//               slave engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package i2c_slave_pkg;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ADDR      = 4'd1,
        ADDR_ACK  = 4'd2,
        PTR       = 4'd3,
        PTR_ACK   = 4'd4,
        WDATA     = 4'd5,
        WDATA_ACK = 4'd6,
        RDATA     = 4'd7,
        RDATA_ACK = 4'd8,
        WAIT_STOP = 4'd9
    } i2cState_t;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;
    localparam logic I2C_RD   = 1'b1;

endpackage

`default_nettype wire

// File: rtl/i2c_bus_monitor.sv
// ============================================================================
// Module      : i2c_bus_monitor
// Description : Synchronizes scl/sda into the clk domain and flags SCL edges
//               plus START/STOP conditions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_bus_monitor #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl,
    input  logic sda,
    output logic scl_r,
    output logic scl_f,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic [SYNC_STAGES-1:0] r_sclSync;
    logic [SYNC_STAGES-1:0] r_sdaSync;
    logic                   r_sclPrev;
    logic                   r_sdaPrev;
    logic                   w_sclS;

    // Idle bus is high; resetting to 1 avoids phantom edges after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sclSync <= '1;
            r_sdaSync <= '1;
            r_sclPrev <= 1'b1;
            r_sdaPrev <= 1'b1;
        end else begin
            r_sclSync <= {r_sclSync[SYNC_STAGES-2:0], scl};
            r_sdaSync <= {r_sdaSync[SYNC_STAGES-2:0], sda};
            r_sclPrev <= r_sclSync[SYNC_STAGES-1];
            r_sdaPrev <= r_sdaSync[SYNC_STAGES-1];
        end
    end

    assign w_sclS    = r_sclSync[SYNC_STAGES-1];
    assign sda_s     = r_sdaSync[SYNC_STAGES-1];
    assign scl_r     =  w_sclS & ~r_sclPrev;
    assign scl_f     = ~w_sclS &  r_sclPrev;
    assign start_det =  w_sclS &  r_sclPrev &  r_sdaPrev & ~sda_s;
    assign stop_det  =  w_sclS &  r_sclPrev & ~r_sdaPrev &  sda_s;

endmodule

`default_nettype wire

// File: rtl/i2c_slave_engine.sv
// ============================================================================
// Module      : i2c_slave_engine
// Description : 7-bit I2C slave bridging bus transfers to a local byte RAM
//               through an auto-incrementing register pointer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_slave_engine
    import i2c_slave_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              scl,
    inout  wire               sda,
    input  logic [6:0]        slave_addr,
    output logic [ADDR_W-1:0] ram_add,
    output logic [7:0]        ram_din,
    output logic              ram_w,
    input  logic [7:0]        ram_dout,
    output logic              busy,
    output logic              stop_evt
);

    i2cState_t         r_state;
    logic [2:0]        r_bitCnt;
    logic [6:0]        r_rxShift;
    logic [6:0]        r_txShift;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_rw;
    logic              r_sdaOe;

    logic              w_sclR;
    logic              w_sclF;
    logic              w_start;
    logic              w_stop;
    logic              w_sdaS;
    logic [7:0]        w_rxByte;

    i2c_bus_monitor #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_busMonitor (
        .clk       (clk),
        .reset     (reset),
        .scl       (scl),
        .sda       (sda),
        .scl_r     (w_sclR),
        .scl_f     (w_sclF),
        .start_det (w_start),
        .stop_det  (w_stop),
        .sda_s     (w_sdaS)
    );

    // Reset gates the driver directly so the bus is freed in the reset cycle.
    assign sda      = (r_sdaOe && !reset) ? 1'b0 : 1'bz;
    assign ram_add  = r_ptr;
    assign w_rxByte = {r_rxShift, w_sdaS};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_bitCnt  <= 3'd0;
            r_rxShift <= 7'd0;
            r_txShift <= 7'd0;
            r_ptr     <= '0;
            r_rw      <= 1'b0;
            r_sdaOe   <= 1'b0;
            ram_din   <= 8'd0;
            ram_w     <= 1'b0;
            busy      <= 1'b0;
            stop_evt  <= 1'b0;
        end else begin
            ram_w    <= 1'b0;
            stop_evt <= 1'b0;
            if (ram_w) begin
                r_ptr <= r_ptr + ADDR_W'(1);
            end

            if (w_stop) begin
                r_state  <= IDLE;
                r_sdaOe  <= 1'b0;
                r_bitCnt <= 3'd0;
                busy     <= 1'b0;
                stop_evt <= 1'b1;
            end else if (w_start) begin
                r_state  <= ADDR;
                r_sdaOe  <= 1'b0;
                r_bitCnt <= 3'd0;
                busy     <= 1'b0;
            end else begin
                case (r_state)
                    ADDR, PTR, WDATA: begin
                        if (w_sclR) begin
                            r_rxShift <= w_rxByte[6:0];
                            r_bitCnt  <= r_bitCnt + 3'd1;
                            if (r_bitCnt == 3'd7) begin
                                if (r_state == PTR) begin
                                    r_ptr   <= ADDR_W'(w_rxByte);
                                    r_state <= PTR_ACK;
                                end else if (r_state == WDATA) begin
                                    ram_din <= w_rxByte;
                                    ram_w   <= 1'b1;
                                    r_state <= WDATA_ACK;
                                end else if (w_rxByte[7:1] == slave_addr) begin
                                    busy    <= 1'b1;
                                    r_rw    <= w_rxByte[0];
                                    r_state <= ADDR_ACK;
                                end else begin
                                    r_state <= WAIT_STOP;
                                end
                            end
                        end
                    end
                    // r_sdaOe doubles as the phase flag: the first scl_f starts
                    // the ACK, the second one ends it.
                    ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                        if (w_sclF) begin
                            r_bitCnt <= 3'd0;
                            if (!r_sdaOe) begin
                                r_sdaOe <= 1'b1;
                            end else if (r_state == ADDR_ACK && r_rw == I2C_RD) begin
                                r_txShift <= ram_dout[6:0];
                                r_sdaOe   <= ~ram_dout[7];
                                r_ptr     <= r_ptr + ADDR_W'(1);
                                r_state   <= RDATA;
                            end else begin
                                r_sdaOe <= 1'b0;
                                r_state <= (r_state == ADDR_ACK) ? PTR : WDATA;
                            end
                        end
                    end
                    RDATA: begin
                        if (w_sclF) begin
                            if (r_bitCnt == 3'd7) begin
                                r_sdaOe  <= 1'b0;
                                r_bitCnt <= 3'd0;
                                r_state  <= RDATA_ACK;
                            end else begin
                                r_sdaOe   <= ~r_txShift[6];
                                r_txShift <= {r_txShift[5:0], 1'b0};
                                r_bitCnt  <= r_bitCnt + 3'd1;
                            end
                        end
                    end
                    // A NACK leaves at scl_r, so any scl_f seen here follows an ACK.
                    RDATA_ACK: begin
                        if (w_sclR && w_sdaS == I2C_NACK) begin
                            busy    <= 1'b0;
                            r_state <= WAIT_STOP;
                        end else if (w_sclF) begin
                            r_txShift <= ram_dout[6:0];
                            r_sdaOe   <= ~ram_dout[7];
                            r_ptr     <= r_ptr + ADDR_W'(1);
                            r_state   <= RDATA;
                        end
                    end
                    default: begin
                        r_sdaOe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_i2c_slave_engine.sv
// ============================================================================
// Module      : tb_i2c_slave_engine
// Description : Directed bench: bit-banged I2C master plus a behavioural RAM.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_i2c_slave_engine;
    import i2c_slave_pkg::*;

    localparam int Q = 10;

    typedef struct {
        logic [6:0] addr;
        logic [7:0] ptr;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       expAck;
        logic [7:0] expPtrAfter;
    } wrVec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl = 1'b1;
    logic       mDrv = 1'b0;
    wire        sda;
    logic [6:0] slaveAddr = 7'h48;
    logic [7:0] ramAdd;
    logic [7:0] ramDin;
    logic [7:0] ramDout = 8'h00;
    logic       ramW;
    logic       busy;
    logic       stopEvt;

    logic [7:0] mem [256];
    int         checks = 0;
    int         errors = 0;
    int         writeCnt = 0;
    int         stopCnt = 0;
    int         stopDouble = 0;
    int         slaveLow = 0;
    int         busyClks = 0;
    logic       prevStop = 1'b0;

    assign sda = mDrv ? 1'b0 : 1'bz;
    pullup (sda);

    always #5 clk = ~clk;

    i2c_slave_engine #(
        .ADDR_W      (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .scl        (scl),
        .sda        (sda),
        .slave_addr (slaveAddr),
        .ram_add    (ramAdd),
        .ram_din    (ramDin),
        .ram_w      (ramW),
        .ram_dout   (ramDout),
        .busy       (busy),
        .stop_evt   (stopEvt)
    );

    always @(posedge clk) begin
        if (ramW) begin
            mem[ramAdd] <= ramDin;
            writeCnt    <= writeCnt + 1;
        end
        ramDout  <= mem[ramAdd];
        prevStop <= stopEvt;
        if (stopEvt) stopCnt <= stopCnt + 1;
        if (stopEvt && prevStop) stopDouble <= stopDouble + 1;
        if (!mDrv && sda === 1'b0) slaveLow <= slaveLow + 1;
        if (busy) busyClks <= busyClks + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Works both from an idle bus and as a repeated START with scl low.
    task automatic busStart();
        mDrv = 1'b0; tick(Q);
        scl  = 1'b1; tick(Q);
        mDrv = 1'b1; tick(Q);
        scl  = 1'b0; tick(Q);
    endtask

    task automatic busStop();
        mDrv = 1'b1; tick(Q);
        scl  = 1'b1; tick(Q);
        mDrv = 1'b0; tick(2*Q);
    endtask

    task automatic putBit(input logic b);
        mDrv = ~b; tick(Q);
        scl  = 1'b1; tick(2*Q);
        scl  = 1'b0; tick(Q);
    endtask

    task automatic getBit(output logic b);
        mDrv = 1'b0; tick(Q);
        scl  = 1'b1; tick(Q);
        b    = sda;  tick(Q);
        scl  = 1'b0; tick(Q);
    endtask

    task automatic sendByte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) putBit(b[i]);
        getBit(ack);
    endtask

    task automatic recvByte(output logic [7:0] b, input logic ack);
        for (int i = 7; i >= 0; i--) getBit(b[i]);
        putBit(ack);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        wrVec_t     vecs [4];
        logic       ack;
        logic [7:0] rd;
        int         w0, s0, l0, b0;

        vecs[0] = '{7'h48, 8'h10, 8'hA5, 8'h3C, 1'b1, 8'h12};
        vecs[1] = '{7'h49, 8'h30, 8'h55, 8'h66, 1'b0, 8'h12};
        vecs[2] = '{7'h48, 8'hFF, 8'h01, 8'h02, 1'b1, 8'h01};
        vecs[3] = '{7'h48, 8'h80, 8'h00, 8'hFF, 1'b1, 8'h82};

        tick(5);
        check("reset_sda", 32'(sda), 32'd1);
        check("reset_ram_add", 32'(ramAdd), 32'h0);
        check("reset_ram_w", 32'(ramW), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_stop_evt", 32'(stopEvt), 32'd0);
        reset = 1'b0;
        tick(10);
        check("idle_ram_din", 32'(ramDin), 32'h0);

        for (int i = 0; i < 4; i++) begin
            w0 = writeCnt; s0 = stopCnt; l0 = slaveLow; b0 = busyClks;
            busStart();
            sendByte({vecs[i].addr, 1'b0}, ack);
            check($sformatf("v%0d_addr_ack", i), 32'(ack), 32'(!vecs[i].expAck));
            check($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].expAck));
            sendByte(vecs[i].ptr, ack);
            check($sformatf("v%0d_ptr_ack", i), 32'(ack), 32'(!vecs[i].expAck));
            sendByte(vecs[i].d0, ack);
            check($sformatf("v%0d_d0_ack", i), 32'(ack), 32'(!vecs[i].expAck));
            sendByte(vecs[i].d1, ack);
            check($sformatf("v%0d_d1_ack", i), 32'(ack), 32'(!vecs[i].expAck));
            busStop();
            check($sformatf("v%0d_stop_cnt", i), 32'(stopCnt - s0), 32'd1);
            check($sformatf("v%0d_busy_end", i), 32'(busy), 32'd0);
            check($sformatf("v%0d_writes", i), 32'(writeCnt - w0), vecs[i].expAck ? 32'd2 : 32'd0);
            check($sformatf("v%0d_ptr_after", i), 32'(ramAdd), 32'(vecs[i].expPtrAfter));
            if (vecs[i].expAck) begin
                check($sformatf("v%0d_mem0", i), 32'(mem[vecs[i].ptr]), 32'(vecs[i].d0));
                check($sformatf("v%0d_mem1", i), 32'(mem[8'(vecs[i].ptr + 8'd1)]), 32'(vecs[i].d1));
            end else begin
                check($sformatf("v%0d_sda_never_low", i), 32'(slaveLow - l0), 32'd0);
                check($sformatf("v%0d_busy_never", i), 32'(busyClks - b0), 32'd0);
            end
        end

        // Preload 0x20..0x22, then pointer write, repeated START and read back.
        busStart();
        sendByte({7'h48, 1'b0}, ack);
        sendByte(8'h20, ack);
        sendByte(8'h11, ack);
        sendByte(8'h22, ack);
        sendByte(8'h33, ack);
        busStop();
        busStart();
        sendByte({7'h48, 1'b0}, ack);
        sendByte(8'h20, ack);
        busStart();
        sendByte({7'h48, I2C_RD}, ack);
        check("rd_addr_ack", 32'(ack), 32'(I2C_ACK));
        recvByte(rd, I2C_ACK);
        check("rd_byte0", 32'(rd), 32'h11);
        recvByte(rd, I2C_ACK);
        check("rd_byte1", 32'(rd), 32'h22);
        recvByte(rd, I2C_NACK);
        check("rd_byte2", 32'(rd), 32'h33);
        tick(2);
        check("rd_sda_released", 32'(sda), 32'd1);
        check("rd_busy_after_nack", 32'(busy), 32'd0);
        busStop();
        check("rd_ptr_after", 32'(ramAdd), 32'h23);

        // STOP after four data bits: pointer updated, partial byte dropped.
        w0 = writeCnt; s0 = stopCnt;
        busStart();
        sendByte({7'h48, 1'b0}, ack);
        sendByte(8'h40, ack);
        putBit(1'b1); putBit(1'b0); putBit(1'b1); putBit(1'b0);
        busStop();
        check("abort_writes", 32'(writeCnt - w0), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ptr", 32'(ramAdd), 32'h40);
        check("abort_stop_cnt", 32'(stopCnt - s0), 32'd1);

        // Reset while the slave drives the MSB (0) of byte 0x11.
        busStart();
        sendByte({7'h48, 1'b0}, ack);
        sendByte(8'h20, ack);
        busStart();
        sendByte({7'h48, I2C_RD}, ack);
        check("rst_msb_driven", 32'(sda), 32'd0);
        check("rst_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("rst_sda_same_clk", 32'(sda), 32'd1);
        @(posedge clk);
        #1;
        check("rst_ram_add", 32'(ramAdd), 32'h0);
        check("rst_ram_din", 32'(ramDin), 32'h0);
        check("rst_ram_w", 32'(ramW), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_stop_evt", 32'(stopEvt), 32'd0);
        mDrv = 1'b0;
        scl  = 1'b1;
        tick(5);
        reset = 1'b0;
        tick(10);
        check("post_rst_sda", 32'(sda), 32'd1);
        check("stop_evt_single_clk", 32'(stopDouble), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
